// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller and its output buffer.
package ram_fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 10;
   localparam int OBUF_DEPTH     = 2;
   localparam int OBUF_PTR_W     = $clog2(OBUF_DEPTH);
   localparam int OBUF_CNT_W     = $clog2(OBUF_DEPTH + 1);
endpackage

// File: rtl/ram_fifo_out_buf.sv
// Two-entry ring buffer that absorbs RAM read data so the read pipeline can run
// one word per cycle while the consumer may stall.
module ram_fifo_out_buf
   import ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [OBUF_CNT_W-1:0] count_o
);

   logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
   logic [OBUF_PTR_W-1:0] head_q, head_d;
   logic [OBUF_PTR_W-1:0] tail_q, tail_d;
   logic [OBUF_CNT_W-1:0] cnt_q, cnt_d;
   logic                  pop;

   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[head_q];
   assign count_o = cnt_q;
   assign pop     = pop_i && valid_o;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (push_i) tail_d = tail_q + OBUF_PTR_W'(1);
      if (pop)    head_d = head_q + OBUF_PTR_W'(1);
      cnt_d = cnt_q + OBUF_CNT_W'(push_i) - OBUF_CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= push_data_i;
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (port A write, port B
// registered read) with a 2-entry output buffer. Define RAM_FIFO_LEVEL_EN to add
// the registered 'level' occupancy output.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_a,
   output logic [ADDR_WIDTH-1:0] addr_a,
   output logic                  we_a,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic                  we_b,
   input  logic [DATA_WIDTH-1:0] q_b
`ifdef RAM_FIFO_LEVEL_EN
   ,
   output logic [ADDR_WIDTH+1:0] level
`endif
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] RAM_DEPTH = PW'(2 ** ADDR_WIDTH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  inflight_q, inflight_d;
   logic [PW-1:0]         ram_count;
   logic                  full, empty;
   logic                  pop, rd_en;
   logic [OBUF_CNT_W-1:0] buf_cnt;
   logic [2:0]            occ, occ_limit;

   // Full/empty come from registered pointers only, so a word written this
   // edge is never read from the same address in the same cycle.
   assign ram_count = wr_ptr_q - rd_ptr_q;
   assign full      = (ram_count == RAM_DEPTH);
   assign empty     = (ram_count == '0);

   assign in_ready = !full && !rst;
   assign we_a     = in_valid && in_ready;
   assign data_a   = in_data;
   assign addr_a   = wr_ptr_q[ADDR_WIDTH-1:0];
   assign addr_b   = rd_ptr_q[ADDR_WIDTH-1:0];
   assign we_b     = 1'b0;

   assign pop       = out_valid && out_ready;
   assign occ       = 3'(buf_cnt) + 3'(inflight_q);
   assign occ_limit = 3'(OBUF_DEPTH) + 3'(pop);
   assign rd_en     = !empty && (occ < occ_limit);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(we_a);
      rd_ptr_d   = rd_ptr_q + PW'(rd_en);
      inflight_d = rd_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
      end
   end

   ram_fifo_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (q_b),
      .pop_i       (pop),
      .valid_o     (out_valid),
      .data_o      (out_data),
      .count_o     (buf_cnt)
   );

`ifdef RAM_FIFO_LEVEL_EN
   // Reads only move words between RAM, pipeline and buffer, so the total
   // changes only on accept and on pop.
   logic [ADDR_WIDTH+1:0] level_q, level_d;

   always_comb begin
      level_d = level_q + (ADDR_WIDTH+2)'(we_a) - (ADDR_WIDTH+2)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= '0;
      else     level_q <= level_d;
   end

   assign level = level_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with ADDR_WIDTH=2 and a 1-cycle-read RAM model.
module tb_ram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] data_a;
   logic [AW-1:0] addr_a;
   logic          we_a;
   logic [AW-1:0] addr_b;
   logic          we_b;
   logic [DW-1:0] q_b;
`ifdef RAM_FIFO_LEVEL_EN
   logic [AW+1:0] level;
`endif

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_a    (data_a),
      .addr_a    (addr_a),
      .we_a      (we_a),
      .addr_b    (addr_b),
      .we_b      (we_b),
      .q_b       (q_b)
`ifdef RAM_FIFO_LEVEL_EN
      ,
      .level     (level)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [2**AW];
   always @(posedge clk) begin
      if (we_a) ram[addr_a] <= data_a;
      q_b <= ram[addr_b];
   end

   typedef struct {
      logic          iv;
      logic [DW-1:0] din;
      logic          ordy;
      logic          e_ir;
      logic          e_ov;
      logic [DW-1:0] e_od;
   } vec_t;

   vec_t          vt [13];
   logic [DW-1:0] exp_q [$];
   int            n_chk = 0;
   int            n_err = 0;
   logic          s_ir, s_ov, s_acc;
   logic [DW-1:0] s_od;
   logic          stall_prev;
   logic [DW-1:0] prev_od;
   logic          first_seen;
   logic [DW-1:0] first_od;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later.
   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
      s_ir  = in_ready;
      s_ov  = out_valid;
      s_od  = out_data;
      s_acc = iv && s_ir;
      chk("we_b", 32'(we_b), 32'd0);
      chk("we_a", 32'(we_a), 32'(s_acc));
      if (s_acc) chk("data_a", 32'(data_a), 32'(d));
      if (stall_prev) begin
         chk("stall_ov", 32'(s_ov), 32'd1);
         chk("stall_od", 32'(s_od), 32'(prev_od));
      end
      if (s_ov && ordy) begin
         if (!first_seen) begin
            first_seen = 1'b1;
            first_od   = s_od;
         end
         if (exp_q.size() == 0) begin
            chk("extra_output", 32'(s_od), 32'hFFFF_FFFF);
         end else begin
            chk("order", 32'(s_od), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
      if (s_acc) exp_q.push_back(d);
      stall_prev = s_ov && !ordy;
      prev_od    = s_od;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] nxt;
      int            sent;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      stall_prev = 1'b0;
      prev_od    = '0;
      first_seen = 1'b0;
      first_od   = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_we_a", 32'(we_a), 32'd0);
      chk("rst_we_b", 32'(we_b), 32'd0);
      chk("rst_addr_a", 32'(addr_a), 32'd0);
      chk("rst_addr_b", 32'(addr_b), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("rst_level", 32'(level), 32'd0);
`endif
      rst = 1'b0;

      // Single word latency, then fill to capacity with the consumer stalled.
      vt[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
      vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vt[5]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[6]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00};
      vt[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01};
      vt[9]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01};
      vt[10] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h01};
      vt[11] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h01};
      vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01};
      for (int i = 0; i < 13; i++) begin
         cycle(vt[i].iv, vt[i].din, vt[i].ordy);
         chk($sformatf("vec%0d_in_ready", i), 32'(s_ir), 32'(vt[i].e_ir));
         chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vt[i].e_ov));
         if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(s_od), 32'(vt[i].e_od));
      end
`ifdef RAM_FIFO_LEVEL_EN
      chk("full_level", 32'(level), 32'd6);
`endif

      // Full FIFO with both sides active: 0x07 retried until accepted.
      nxt = 8'h07;
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, nxt, 1'b1);
         if (k == 0) chk("full_rw_in_ready0", 32'(s_ir), 32'd0);
         if (k == 1) chk("full_rw_in_ready1", 32'(s_ir), 32'd1);
         if (s_acc) nxt = nxt + 8'h01;
      end
      chk("full_rw_accepted", 32'(nxt), 32'h10);
      for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00, 1'b1);
      chk("full_rw_left", 32'(exp_q.size()), 32'd0);
      chk("full_rw_drained", 32'(s_ov), 32'd0);

      // Streaming 20 words from empty: first out in cycle 3, then one per cycle.
      for (int k = 0; k < 24; k++) begin
         cycle(k < 20, 8'h40 + 8'(k), 1'b1);
         if (k < 20) chk($sformatf("stream%0d_in_ready", k), 32'(s_ir), 32'd1);
         chk($sformatf("stream%0d_out_valid", k), 32'(s_ov), 32'((k >= 3) && (k < 23)));
      end
      chk("stream_left", 32'(exp_q.size()), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("stream_level", 32'(level), 32'd0);
`endif

      // Asynchronous reset with three words stored.
      cycle(1'b1, 8'h31, 1'b0);
      cycle(1'b1, 8'h32, 1'b0);
      cycle(1'b1, 8'h33, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("pre_rst_out_valid", 32'(s_ov), 32'd1);
      @(negedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd0);
      chk("async_rst_addr_a", 32'(addr_a), 32'd0);
      chk("async_rst_addr_b", 32'(addr_b), 32'd0);
`ifdef RAM_FIFO_LEVEL_EN
      chk("async_rst_level", 32'(level), 32'd0);
`endif
      @(negedge clk);
      rst        = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
      first_seen = 1'b0;
      cycle(1'b1, 8'hAA, 1'b1);
      cycle(1'b1, 8'hBB, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b1);
      chk("post_rst_seen", 32'(first_seen), 32'd1);
      chk("post_rst_first", 32'(first_od), 32'hAA);
      chk("post_rst_left", 32'(exp_q.size()), 32'd0);

      // Consumer toggling ready every cycle.
      sent = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(sent < 5, 8'h60 + 8'(sent), k[0]);
         if (s_acc) sent++;
      end
      chk("toggle_sent", 32'(sent), 32'd5);
      chk("toggle_left", 32'(exp_q.size()), 32'd0);
      chk("toggle_drained", 32'(s_ov), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
